// File: rtl/sr_flag_unit.sv
// Purpose: next-state generator for the CPU status word, with a shadow stack for interrupt save and restore.
// Latency: every update appears on SRSet one clk edge after the inputs; with no event SRSet holds.
// Backpressure: none; every input is consumed each cycle. Stack overflow and underflow set the sticky stackErr.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   aluValid/aluResult/aluCarry/aluOverflow/aluHalf/flagMask
//                         ALU flag merge; flagMask is {H,V,N,Z}, and C always follows aluCarry
//   flagOp/bitSel/loadData
//                         0 NOP, 1 SETBIT, 2 CLRBIT, 3 LOAD, 4 IRQ_ENTER, 5 RETI, 6/7 NOP
//   clrErr                clears stackErr (a new error in the same cycle wins)
//   SRSet                 registered status word {P,T,H,I,V,N,Z,C}
//   stackLevel            number of valid shadow entries
//   stackErr              sticky overflow/underflow flag
//
// Optional feature: define SR_PARITY_FLAG_EN to make bit 7 a parity flag (P).
// P is the even parity of aluResult, taken when flagMask[0] is set.
// Without the macro, bit 7 is held at 0.
// Parameters: DEPTH in 2..8, and 2**PTRW must exceed DEPTH.
module sr_flag_unit #(
    parameter int DEPTH = 4,
    parameter int PTRW  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            aluValid,
    input  logic [7:0]      aluResult,
    input  logic            aluCarry,
    input  logic            aluOverflow,
    input  logic            aluHalf,
    input  logic [3:0]      flagMask,
    input  logic [2:0]      flagOp,
    input  logic [2:0]      bitSel,
    input  logic [7:0]      loadData,
    input  logic            clrErr,
    output logic [7:0]      SRSet,
    output logic [PTRW-1:0] stackLevel,
    output logic            stackErr
);

    localparam logic [2:0] OP_SETBIT = 3'd1;
    localparam logic [2:0] OP_CLRBIT = 3'd2;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_IRQ    = 3'd4;
    localparam logic [2:0] OP_RETI   = 3'd5;

    logic [7:0]      sr_q, sr_d;
    logic [PTRW-1:0] level_q, level_d;
    logic            err_q, err_d;
    logic [7:0]      stack_q [DEPTH];
    logic [7:0]      stack_d [DEPTH];

    logic [7:0]      merged;
    logic [7:0]      top;
    logic            full;
    logic            empty;
    logic            new_err;

    always_comb begin
        // ALU merge. RETI ignores the ALU entirely.
        merged = sr_q;
        if (aluValid && (flagOp != OP_RETI)) begin
            merged[0] = aluCarry;
            if (flagMask[0]) begin
                merged[1] = (aluResult == 8'h00);
`ifdef SR_PARITY_FLAG_EN
                merged[7] = ~^aluResult;
`endif
            end
            if (flagMask[1]) merged[2] = aluResult[7];
            if (flagMask[2]) merged[3] = aluOverflow;
            if (flagMask[3]) merged[5] = aluHalf;
        end

        // Stack entries are indexed by loop compare, which keeps the
        // pointer width independent of the array index width.
        top = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (level_q == PTRW'(i + 1)) top = stack_q[i];
        end
        full  = (level_q == PTRW'(DEPTH));
        empty = (level_q == '0);

        sr_d    = merged;
        level_d = level_q;
        stack_d = stack_q;
        new_err = 1'b0;

        case (flagOp)
            OP_SETBIT: sr_d[bitSel] = 1'b1;
            OP_CLRBIT: sr_d[bitSel] = 1'b0;
            OP_LOAD:   sr_d = loadData;
            OP_IRQ: begin
                if (full) begin
                    new_err = 1'b1;
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (level_q == PTRW'(i)) stack_d[i] = merged;
                    end
                    level_d = level_q + PTRW'(1);
                end
                // I is cleared on interrupt entry, even when the push fails.
                sr_d[4] = 1'b0;
            end
            OP_RETI: begin
                if (empty) begin
                    sr_d    = sr_q;
                    new_err = 1'b1;
                end else begin
                    sr_d    = top;
                    level_d = level_q - PTRW'(1);
                end
            end
            default: ;
        endcase

`ifndef SR_PARITY_FLAG_EN
        sr_d[7] = 1'b0;
`endif

        // A new error takes precedence over clrErr.
        err_d = new_err | (err_q & ~clrErr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q    <= 8'h00;
            level_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= 8'h00;
        end else begin
            sr_q    <= sr_d;
            level_q <= level_d;
            err_q   <= err_d;
            stack_q <= stack_d;
        end
    end

    assign SRSet      = sr_q;
    assign stackLevel = level_q;
    assign stackErr   = err_q;

endmodule

// File: tb/tb_sr_flag_unit.sv
// Purpose: self-checking bench for sr_flag_unit, combining directed scenarios with randomized traffic.
// Expected values come from a queue-based reference model of the status word rules.
// Outputs are sampled on the falling clock edge; inputs are driven there too.
module tb_sr_flag_unit;

    localparam int DEPTH = 4;
    localparam int PTRW  = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            aluValid;
    logic [7:0]      aluResult;
    logic            aluCarry;
    logic            aluOverflow;
    logic            aluHalf;
    logic [3:0]      flagMask;
    logic [2:0]      flagOp;
    logic [2:0]      bitSel;
    logic [7:0]      loadData;
    logic            clrErr;
    logic [7:0]      SRSet;
    logic [PTRW-1:0] stackLevel;
    logic            stackErr;

    sr_flag_unit #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
        .clk(clk), .rst_n(rst_n),
        .aluValid(aluValid), .aluResult(aluResult), .aluCarry(aluCarry),
        .aluOverflow(aluOverflow), .aluHalf(aluHalf), .flagMask(flagMask),
        .flagOp(flagOp), .bitSel(bitSel), .loadData(loadData), .clrErr(clrErr),
        .SRSet(SRSet), .stackLevel(stackLevel), .stackErr(stackErr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state: the status word, a LIFO of saved words, and the error flag.
    logic [7:0] m_sr;
    logic [7:0] m_stack[$];
    logic       m_err;

    // Model of bit 7 in this build: 1 when bit 7 is a real flag, 0 when it is forced low.
`ifdef SR_PARITY_FLAG_EN
    localparam bit HAS_P = 1'b1;
`else
    localparam bit HAS_P = 1'b0;
`endif

    task automatic model_reset();
        m_sr  = 8'h00;
        m_err = 1'b0;
        m_stack.delete();
    endtask

    task automatic model_step();
        logic c, z, n, v, i_f, h, t, p;
        logic [7:0] word;
        bit err_now;
        {p, t, h, i_f, v, n, z, c} = m_sr;
        err_now = 0;
        if (aluValid && flagOp != 3'd5) begin
            c = aluCarry;
            if (flagMask[0]) begin
                z = (aluResult == 0);
                if (HAS_P) p = ($countones(aluResult) % 2 == 0);
            end
            if (flagMask[1]) n = aluResult[7];
            if (flagMask[2]) v = aluOverflow;
            if (flagMask[3]) h = aluHalf;
        end
        word = {p, t, h, i_f, v, n, z, c};
        case (flagOp)
            3'd1: word = word | (8'h01 << bitSel);
            3'd2: word = word & ~(8'h01 << bitSel);
            3'd3: word = loadData;
            3'd4: begin
                if (m_stack.size() == DEPTH) err_now = 1;
                else m_stack.push_back(word);
                word = word & 8'hEF;
            end
            3'd5: begin
                if (m_stack.size() == 0) begin
                    word    = m_sr;
                    err_now = 1;
                end else begin
                    word = m_stack.pop_back();
                end
            end
            default: ;
        endcase
        if (!HAS_P) word = word & 8'h7F;
        m_sr = word;
        if (err_now) m_err = 1'b1;
        else if (clrErr) m_err = 1'b0;
    endtask

    task automatic idle_inputs();
        aluValid = 0; aluResult = 0; aluCarry = 0; aluOverflow = 0; aluHalf = 0;
        flagMask = 0; flagOp = 0; bitSel = 0; loadData = 0; clrErr = 0;
    endtask

    // One cycle: advance the model with the current inputs, clock, then compare all outputs.
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check({tag, ".sr"},  {24'h0, SRSet}, {24'h0, m_sr});
        check({tag, ".lvl"}, {29'h0, stackLevel}, m_stack.size());
        check({tag, ".err"}, {31'h0, stackErr}, {31'h0, m_err});
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #23;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state, then five idle cycles.
        for (int i = 0; i < 5; i++) tick("idle");
        check("rst_sr",  {24'h0, SRSet}, 32'h00);
        check("rst_lvl", {29'h0, stackLevel}, 32'h0);
        check("rst_err", {31'h0, stackErr}, 32'h0);

        // Full ALU merge of a zero result.
        aluValid = 1; aluResult = 8'h00; aluCarry = 1; flagMask = 4'b1111; aluHalf = 1;
        tick("alu_all");
        check("alu_all_const", {24'h0, SRSet}, HAS_P ? 32'hA3 : 32'h23);

        // CLRBIT overrides the ALU on the N bit.
        flagOp = 3'd3; loadData = 8'h10; tick("load10");
        aluValid = 1; aluResult = 8'h80; flagMask = 4'b0010; flagOp = 3'd2; bitSel = 3'd2;
        tick("clr_n");
        check("clr_n_const", {24'h0, SRSet}, 32'h10);
        aluValid = 1; aluResult = 8'h80; aluCarry = 1; flagMask = 4'b0010; flagOp = 3'd2; bitSel = 3'd2;
        tick("clr_n_c");
        check("clr_n_c_const", {24'h0, SRSet}, 32'h11);

        // Writing bit 7 only takes effect when the parity flag exists.
        flagOp = 3'd3; loadData = 8'hFF; tick("loadff");
        check("loadff_const", {24'h0, SRSet}, HAS_P ? 32'hFF : 32'h7F);

        // Fill the stack, overflow it, then unwind it.
        flagOp = 3'd3; loadData = 8'h5A; tick("load5a");
        for (int i = 0; i < DEPTH; i++) begin
            flagOp = 3'd4; tick("push");
        end
        check("full_lvl", {29'h0, stackLevel}, DEPTH);
        check("full_sr",  {24'h0, SRSet}, 32'h4A);

        // Mid-cycle asynchronous reset while the stack holds entries.
        #2 rst_n = 1'b0;
        #1;
        check("arst_sr",  {24'h0, SRSet}, 32'h0);
        check("arst_lvl", {29'h0, stackLevel}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        flagOp = 3'd3; loadData = 8'h5A; tick("load5a_b");
        for (int i = 0; i < DEPTH; i++) begin
            flagOp = 3'd4; tick("push_b");
        end
        flagOp = 3'd4; tick("overflow");
        check("ovf_err", {31'h0, stackErr}, 32'h1);
        check("ovf_lvl", {29'h0, stackLevel}, DEPTH);
        for (int i = 0; i < DEPTH - 1; i++) begin
            flagOp = 3'd5; tick("pop");
        end
        // The final pop happens with an ALU carry present, and that carry must be ignored.
        flagOp = 3'd5; aluValid = 1; aluCarry = 1; flagMask = 4'b1111; tick("pop_last");
        check("pop_last_const", {24'h0, SRSet}, 32'h5A);

        // Underflow, then clear the error, then clear and underflow together.
        clrErr = 1; tick("clr");
        check("clr_const", {31'h0, stackErr}, 32'h0);
        flagOp = 3'd5; tick("underflow");
        check("unf_err", {31'h0, stackErr}, 32'h1);
        check("unf_sr",  {24'h0, SRSet}, 32'h5A);
        clrErr = 1; tick("clr2");
        flagOp = 3'd5; clrErr = 1; tick("clr_and_unf");
        check("clr_unf_const", {31'h0, stackErr}, 32'h1);

        // Randomized traffic, biased towards stack operations so both stack boundaries are reached.
        for (int k = 0; k < 3000; k++) begin
            aluValid    = 1'($urandom);
            aluResult   = 8'($urandom);
            aluCarry    = 1'($urandom);
            aluOverflow = 1'($urandom);
            aluHalf     = 1'($urandom);
            flagMask    = 4'($urandom);
            bitSel      = 3'($urandom);
            loadData    = 8'($urandom);
            clrErr      = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 9))
                0, 1, 2: flagOp = 3'd4;
                3, 4, 5: flagOp = 3'd5;
                default: flagOp = 3'($urandom);
            endcase
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
